// File: rtl/seletor_operandos_alu.sv
// seletor_operandos_alu
//   Registered operand-select stage sitting between ID and EX. Picks ALU
//   operands A and B with EX/WB forwarding, extends the immediate, stalls on
//   load-use hazards and talks valid/ready on both sides.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   flush                   drop the held output and any pending stall
//   entrada_valida/_pronta  upstream handshake
//   rs1, rs2, br_dado1/2    source indices and register-file read data
//   imediato, imm_sinal     raw immediate and sign/zero extension select
//   alu_src                 B select: 00 reg2, 01 imm, 10 pc_mais4, 11 reg2
//   pc_mais4                link value
//   ex_* / wb_*             forwarding sources and load-use detection
//   saida_valida/_pronta    downstream handshake
//   operando_a, operando_b  registered operands
//   bolha                   high while stalling for a load-use hazard
module seletor_operandos_alu #(
    parameter int DATA_WIDTH     = 32,
    parameter int IMM_WIDTH      = 16,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCIA  = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      entrada_valida,
    output logic                      entrada_pronta,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]     br_dado1,
    input  logic [DATA_WIDTH-1:0]     br_dado2,
    input  logic [IMM_WIDTH-1:0]      imediato,
    input  logic                      imm_sinal,
    input  logic [1:0]                alu_src,
    input  logic [DATA_WIDTH-1:0]     pc_mais4,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_escreve,
    input  logic                      ex_eh_load,
    input  logic [DATA_WIDTH-1:0]     ex_resultado,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      wb_escreve,
    input  logic [DATA_WIDTH-1:0]     wb_resultado,
    output logic                      saida_valida,
    input  logic                      saida_pronta,
    output logic [DATA_WIDTH-1:0]     operando_a,
    output logic [DATA_WIDTH-1:0]     operando_b,
    output logic                      bolha
);

    // Counter only needs to hold LOAD_LATENCIA-1.
    localparam int CW = (LOAD_LATENCIA > 1) ? $clog2(LOAD_LATENCIA) : 1;

    typedef enum logic {LIVRE, ESPERA} estado_t;

    estado_t                estado_q, estado_d;
    logic [CW-1:0]          cont_q, cont_d;
    logic                   valida_q;
    logic [DATA_WIDTH-1:0]  op_a_q, op_b_q;

    logic [DATA_WIDTH-1:0]  fwd_a, fwd_b, sel_b, imm_ext;
    logic                   usa_rs2, hazard, aceita;

    // EX result beats WB data; a load in EX has no usable result yet.
    function automatic logic [DATA_WIDTH-1:0] encaminha(
        input logic [REG_ADDR_WIDTH-1:0] s,
        input logic [DATA_WIDTH-1:0]     br,
        input logic [REG_ADDR_WIDTH-1:0] erd,
        input logic                      eesc,
        input logic                      eload,
        input logic [DATA_WIDTH-1:0]     eres,
        input logic [REG_ADDR_WIDTH-1:0] wrd,
        input logic                      wesc,
        input logic [DATA_WIDTH-1:0]     wres
    );
        if (s == '0)                             return '0;
        else if (eesc && !eload && erd == s)     return eres;
        else if (wesc && wrd == s)               return wres;
        else                                     return br;
    endfunction

    assign fwd_a = encaminha(rs1, br_dado1, ex_rd, ex_escreve, ex_eh_load, ex_resultado,
                             wb_rd, wb_escreve, wb_resultado);
    assign fwd_b = encaminha(rs2, br_dado2, ex_rd, ex_escreve, ex_eh_load, ex_resultado,
                             wb_rd, wb_escreve, wb_resultado);

    generate
        if (IMM_WIDTH == DATA_WIDTH) begin : g_imm_pass
            assign imm_ext = imediato;
        end else begin : g_imm_ext
            assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm_sinal & imediato[IMM_WIDTH-1]}}, imediato};
        end
    endgenerate

    always_comb begin
        sel_b = fwd_b;
        case (alu_src)
            2'b01:   sel_b = imm_ext;
            2'b10:   sel_b = pc_mais4;
            default: sel_b = fwd_b;
        endcase
    end

    // rs2 only matters for a hazard when B actually reads the register.
    assign usa_rs2 = (alu_src == 2'b00) || (alu_src == 2'b11);
    assign hazard  = entrada_valida & ex_escreve & ex_eh_load & (ex_rd != '0) &
                     ((ex_rd == rs1) | ((ex_rd == rs2) & usa_rs2));

    assign entrada_pronta = (estado_q == LIVRE) & ~hazard & ~flush &
                            (~valida_q | saida_pronta);
    assign aceita = entrada_valida & entrada_pronta;

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        bolha    = 1'b0;
        case (estado_q)
            LIVRE: begin
                if (hazard) begin
                    estado_d = ESPERA;
                    cont_d   = CW'(LOAD_LATENCIA - 1);
                end
            end
            ESPERA: begin
                bolha = 1'b1;
                if (cont_q == '0) estado_d = LIVRE;
                else              cont_d   = cont_q - 1'b1;
            end
            default: estado_d = LIVRE;
        endcase
        if (flush) begin
            estado_d = LIVRE;
            cont_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= LIVRE;
            cont_q   <= '0;
            valida_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            if (flush) begin
                valida_q <= 1'b0;
            end else if (aceita) begin
                valida_q <= 1'b1;
                op_a_q   <= fwd_a;
                op_b_q   <= sel_b;
            end else if (saida_pronta) begin
                valida_q <= 1'b0;
            end
        end
    end

    assign saida_valida = valida_q;
    assign operando_a   = op_a_q;
    assign operando_b   = op_b_q;

endmodule

// File: tb/tb_seletor_operandos_alu.sv
// Bench for seletor_operandos_alu: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_seletor_operandos_alu;

    localparam int DW  = 32;
    localparam int IW  = 16;
    localparam int RAW = 5;
    localparam int LAT = 2;

    logic           clock, reset, flush, entrada_valida, entrada_pronta;
    logic [RAW-1:0] rs1, rs2, ex_rd, wb_rd;
    logic [DW-1:0]  br_dado1, br_dado2, pc_mais4, ex_resultado, wb_resultado;
    logic [IW-1:0]  imediato;
    logic           imm_sinal, ex_escreve, ex_eh_load, wb_escreve;
    logic [1:0]     alu_src;
    logic           saida_valida, saida_pronta, bolha;
    logic [DW-1:0]  operando_a, operando_b;

    seletor_operandos_alu #(
        .DATA_WIDTH(DW), .IMM_WIDTH(IW), .REG_ADDR_WIDTH(RAW), .LOAD_LATENCIA(LAT)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta),
        .rs1(rs1), .rs2(rs2), .br_dado1(br_dado1), .br_dado2(br_dado2),
        .imediato(imediato), .imm_sinal(imm_sinal), .alu_src(alu_src),
        .pc_mais4(pc_mais4), .ex_rd(ex_rd), .ex_escreve(ex_escreve),
        .ex_eh_load(ex_eh_load), .ex_resultado(ex_resultado), .wb_rd(wb_rd),
        .wb_escreve(wb_escreve), .wb_resultado(wb_resultado),
        .saida_valida(saida_valida), .saida_pronta(saida_pronta),
        .operando_a(operando_a), .operando_b(operando_b), .bolha(bolha)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- reference model state ----
    bit            m_valid;
    logic [DW-1:0] m_a, m_b;
    int            m_stall;   // bubble cycles still to be emitted

    function automatic logic [DW-1:0] ref_fwd(input int s, input logic [DW-1:0] rf);
        if (s == 0) return '0;
        if (ex_escreve && !ex_eh_load && int'(ex_rd) == s) return ex_resultado;
        if (wb_escreve && int'(wb_rd) == s) return wb_resultado;
        return rf;
    endfunction

    function automatic logic [DW-1:0] ref_imm();
        longint v;
        logic [63:0] t;
        v = longint'(imediato);
        if (imm_sinal && v >= (longint'(1) << (IW-1))) v = v - (longint'(1) << IW);
        t = v;
        return t[DW-1:0];
    endfunction

    function automatic bit ref_hazard();
        bit b_reads_reg;
        b_reads_reg = (alu_src == 2'd0) || (alu_src == 2'd3);
        return entrada_valida && ex_escreve && ex_eh_load && ex_rd != 0 &&
               (ex_rd == rs1 || (ex_rd == rs2 && b_reads_reg));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = '0; m_b = '0; m_stall = 0;
    endtask

    // Called right after a falling edge with inputs driven: checks the current
    // cycle, advances the model across the next rising edge, returns at the
    // following falling edge.
    task automatic step();
        bit hz, pr, n_valid;
        int n_stall;
        logic [DW-1:0] ea, eb, n_a, n_b;
        #1;
        hz = ref_hazard();
        pr = (m_stall == 0) && !hz && !flush && (!m_valid || saida_pronta);
        ea = ref_fwd(int'(rs1), br_dado1);
        case (alu_src)
            2'd1:    eb = ref_imm();
            2'd2:    eb = pc_mais4;
            default: eb = ref_fwd(int'(rs2), br_dado2);
        endcase
        chk("entrada_pronta", entrada_pronta, pr);
        chk("bolha", bolha, m_stall > 0);
        chk("saida_valida", saida_valida, m_valid);
        if (m_valid) begin
            chk("operando_a", operando_a, m_a);
            chk("operando_b", operando_b, m_b);
        end
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_stall = m_stall;
        if (flush) begin
            n_valid = 0; n_stall = 0;
        end else begin
            if (m_stall > 0) n_stall = m_stall - 1;
            else if (hz)     n_stall = LAT;
            if (entrada_valida && pr) begin
                n_valid = 1; n_a = ea; n_b = eb;
            end else if (saida_pronta) begin
                n_valid = 0;
            end
        end
        @(posedge clock);
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_stall = n_stall;
        @(negedge clock);
    endtask

    task automatic idle();
        flush = 0; entrada_valida = 0; rs1 = 0; rs2 = 0;
        br_dado1 = '0; br_dado2 = '0; imediato = '0; imm_sinal = 0; alu_src = 0;
        pc_mais4 = '0; ex_rd = 0; ex_escreve = 0; ex_eh_load = 0; ex_resultado = '0;
        wb_rd = 0; wb_escreve = 0; wb_resultado = '0; saida_pronta = 1;
    endtask

    task automatic load_hazard();
        idle();
        entrada_valida = 1; ex_escreve = 1; ex_eh_load = 1; ex_rd = 3;
        rs1 = 1; rs2 = 3; alu_src = 0;
    endtask

    task automatic async_reset();
        #2 reset = 1;
        #1;
        chk("rst_valida", saida_valida, 0);
        chk("rst_bolha", bolha, 0);
        chk("rst_op_a", operando_a, 0);
        chk("rst_op_b", operando_b, 0);
        model_reset();
        reset = 0;
    endtask

    logic [DW-1:0] held;

    initial begin
        reset = 1;
        idle();
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_valida", saida_valida, 0);
        chk("reset_op_a", operando_a, 0);
        chk("reset_op_b", operando_b, 0);
        chk("reset_bolha", bolha, 0);
        reset = 0;

        // immediate extension
        entrada_valida = 1; alu_src = 1; imediato = 16'hFFF0; imm_sinal = 1;
        step();
        chk("t1_sext", operando_b, 32'hFFFFFFF0);
        imm_sinal = 0;
        step();
        chk("t1_zext", operando_b, 32'h0000FFF0);

        // forwarding priority and x0
        alu_src = 0; rs1 = 5; ex_rd = 5; wb_rd = 5; ex_escreve = 1; wb_escreve = 1;
        ex_resultado = 7; wb_resultado = 9; br_dado1 = 123;
        step();
        chk("t2_ex_wins", operando_a, 7);
        rs1 = 0;
        step();
        chk("t2_x0", operando_a, 0);

        // load-use stall on rs2
        load_hazard();
        #1 chk("t3_detect", entrada_pronta, 0);
        step();
        ex_eh_load = 0; ex_escreve = 0;
        for (int i = 0; i < LAT; i++) begin
            #1 chk("t3_bolha", bolha, 1);
            chk("t3_pronta", entrada_pronta, 0);
            step();
        end
        #1 chk("t3_release", entrada_pronta, 1);
        chk("t3_bolha_off", bolha, 0);
        step();
        chk("t3_accepted", saida_valida, 1);

        // same hazard but B uses immediate: no stall
        load_hazard();
        alu_src = 1;
        #1 chk("t4_pronta", entrada_pronta, 1);
        step();
        chk("t4_accepted", saida_valida, 1);

        // backpressure hold and release
        idle();
        entrada_valida = 1; rs1 = 2; br_dado1 = $urandom;
        held = br_dado1;
        step();
        saida_pronta = 0;
        for (int i = 0; i < 3; i++) begin
            br_dado1 = $urandom;
            #1 chk("t5_pronta", entrada_pronta, 0);
            step();
            chk("t5_stable", operando_a, held);
        end
        saida_pronta = 1;
        for (int i = 0; i < 3; i++) begin
            br_dado1 = $urandom;
            held = br_dado1;
            step();
            chk("t5_b2b_valida", saida_valida, 1);
            chk("t5_b2b_data", operando_a, held);
        end

        // flush during stall
        load_hazard();
        step();
        ex_eh_load = 0; flush = 1;
        step();
        flush = 0;
        #1 chk("t6_stall_valida", saida_valida, 0);
        chk("t6_stall_bolha", bolha, 0);
        chk("t6_stall_pronta", entrada_pronta, 1);
        step();

        // flush during held output
        idle();
        entrada_valida = 1;
        step();
        saida_pronta = 0;
        step();
        flush = 1;
        step();
        flush = 0;
        #1 chk("t6_hold_valida", saida_valida, 0);
        chk("t6_hold_pronta", entrada_pronta, 1);
        step();

        // async reset mid-stall and mid-hold
        load_hazard();
        step();
        ex_eh_load = 0;
        async_reset();
        step();
        idle();
        entrada_valida = 1; br_dado1 = 32'h1234; rs1 = 4;
        step();
        saida_pronta = 0;
        async_reset();
        step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            entrada_valida = ($urandom_range(0, 9) < 8);
            rs1 = RAW'($urandom_range(0, 3));
            rs2 = RAW'($urandom_range(0, 3));
            ex_rd = RAW'($urandom_range(0, 3));
            wb_rd = RAW'($urandom_range(0, 3));
            ex_escreve = $urandom_range(0, 1);
            ex_eh_load = ($urandom_range(0, 3) == 0);
            wb_escreve = $urandom_range(0, 1);
            br_dado1 = $urandom; br_dado2 = $urandom;
            ex_resultado = $urandom; wb_resultado = $urandom; pc_mais4 = $urandom;
            imediato = IW'($urandom); imm_sinal = $urandom_range(0, 1);
            alu_src = 2'($urandom_range(0, 3));
            saida_pronta = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) async_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
